// File: rtl/cbsc_pkg.sv
// Shared CBSC definitions: binary word widths, saturation limit and the decoder state encoding.
package cbsc_pkg;
  localparam int BN_W  = 7;
  localparam int CNT_W = BN_W + 1;
  localparam logic [BN_W-1:0] SAT_MAX = 7'd127;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
endpackage

// File: rtl/cbsc_sn_decoder_ones_counter.sv
// Counts ones on a serial stochastic bitstream; clr has priority over en.
module sn_ones_counter
  import cbsc_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             sn_in,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(sn_in);
    end
  end

endmodule

// File: rtl/cbsc_sn_decoder.sv
// Stochastic-to-binary decoder: counts ones over a programmable frame, adds a bias and saturates to 7 bits.
module cbsc_sn_decoder
  import cbsc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [BN_W-1:0] len,
  input  logic [BN_W-1:0] bias,
  input  logic            sn_in,
  output logic            busy,
  output logic            valid,
  output logic [BN_W-1:0] Q,
  output logic            ovf
);

  // Returns {overflow, saturated result}; the sum never exceeds 128+127, so CNT_W bits suffice.
  function automatic logic [BN_W:0] sat_add(input logic [CNT_W-1:0] c,
                                            input logic [BN_W-1:0]  b);
    logic [CNT_W-1:0] sum;
    sum = c + CNT_W'(b);
    if (sum > CNT_W'(SAT_MAX)) return {1'b1, SAT_MAX};
    else                       return {1'b0, sum[BN_W-1:0]};
  endfunction

  state_t           state_q;
  logic [CNT_W-1:0] rem_q;
  logic [BN_W-1:0]  bias_q;
  logic [BN_W-1:0]  q_q;
  logic             busy_q, valid_q, ovf_q;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr, cnt_en;
  logic [BN_W:0]    res_d;

  assign cnt_clr = rst || (state_q == IDLE && start);
  assign cnt_en  = (state_q == COUNT);
  assign res_d   = sat_add(cnt, bias_q);

  sn_ones_counter u_cnt (
    .clk   (clk),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .sn_in (sn_in),
    .cnt   (cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      bias_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      q_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (start) begin
            // A zero length field encodes the full 128-sample frame.
            rem_q   <= (len == '0) ? CNT_W'(128) : CNT_W'(len);
            bias_q  <= bias;
            busy_q  <= 1'b1;
            state_q <= COUNT;
          end
        end
        COUNT: begin
          valid_q <= 1'b0;
          rem_q   <= rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) state_q <= DONE;
        end
        DONE: begin
          q_q     <= res_d[BN_W-1:0];
          ovf_q   <= res_d[BN_W];
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign Q     = q_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_cbsc_sn_decoder.sv
// Directed bench for cbsc_sn_decoder: frame timing, saturation, protocol and reset behaviour.
module tb_cbsc_sn_decoder;
  logic       clk = 1'b0;
  logic       rst, start, sn_in;
  logic [6:0] len, bias;
  logic       busy, valid, ovf;
  logic [6:0] Q;

  int n_assert = 0;
  int n_fail   = 0;

  cbsc_sn_decoder dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .len   (len),
    .bias  (bias),
    .sn_in (sn_in),
    .busy  (busy),
    .valid (valid),
    .Q     (Q),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one frame from the start edge to the valid edge; ends inside the valid cycle.
  task automatic frame(input string tag, input int L, input logic [6:0] len_v,
                       input logic [6:0] bias_v, input logic [127:0] bits,
                       input logic [6:0] exp_q, input logic exp_ovf);
    len = len_v; bias = bias_v; start = 1'b1;
    tick();
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    start = 1'b0;
    len = 7'h55; bias = 7'h7f;
    for (int i = 0; i < L; i++) begin
      sn_in = bits[i];
      start = (i == 1);
      tick();
      chk({tag, "_valid_cnt"}, 32'(valid), 32'd0);
      chk({tag, "_busy_cnt"}, 32'(busy), 32'd1);
    end
    sn_in = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    chk({tag, "_Q"}, 32'(Q), 32'(exp_q));
    chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
  endtask

  task automatic idle_after(input string tag, input logic [6:0] exp_q, input logic exp_ovf);
    tick();
    chk({tag, "_valid_drop"}, 32'(valid), 32'd0);
    chk({tag, "_Q_hold"}, 32'(Q), 32'(exp_q));
    chk({tag, "_ovf_hold"}, 32'(ovf), 32'(exp_ovf));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sn_in = 1'b0; len = '0; bias = '0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_Q", 32'(Q), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    tick();

    // Nominal: 1,0,1,1 plus bias 2 -> 5
    frame("nom", 4, 7'd4, 7'd2, 128'hD, 7'd5, 1'b0);
    idle_after("nom", 7'd5, 1'b0);

    // Full 128-sample frames
    frame("full1", 128, 7'd0, 7'd0, {128{1'b1}}, 7'd127, 1'b1);
    idle_after("full1", 7'd127, 1'b1);
    frame("full0", 128, 7'd0, 7'd0, 128'd0, 7'd0, 1'b0);
    idle_after("full0", 7'd0, 1'b0);

    // Bias saturation around the 127 boundary with 30 ones
    frame("b100", 64, 7'd64, 7'd100, 128'h3FFF_FFFF, 7'd127, 1'b1);
    idle_after("b100", 7'd127, 1'b1);
    frame("b97", 64, 7'd64, 7'd97, 128'h3FFF_FFFF, 7'd127, 1'b0);
    idle_after("b97", 7'd127, 1'b0);
    frame("b98", 64, 7'd64, 7'd98, 128'h3FFF_FFFF, 7'd127, 1'b1);
    idle_after("b98", 7'd127, 1'b1);

    // Start in the valid cycle launches the next frame; result L+1 edges later
    frame("chainA", 5, 7'd5, 7'd10, 128'h1F, 7'd15, 1'b0);
    frame("chainB", 3, 7'd3, 7'd1, 128'h5, 7'd3, 1'b0);
    idle_after("chainB", 7'd3, 1'b0);

    // Minimum-length frames back to back
    frame("min1", 1, 7'd1, 7'd0, 128'h1, 7'd1, 1'b0);
    frame("min2", 1, 7'd1, 7'd5, 128'h0, 7'd5, 1'b0);
    frame("min3", 1, 7'd1, 7'd127, 128'h1, 7'd127, 1'b1);
    idle_after("min3", 7'd127, 1'b1);

    // Reset at edge k+3 of a len=10 frame discards it
    len = 7'd10; bias = 7'd3; start = 1'b1; sn_in = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_valid", 32'(valid), 32'd0);
    chk("mrst_Q", 32'(Q), 32'd0);
    chk("mrst_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("mrst_no_valid", 32'(valid), 32'd0);
    end
    sn_in = 1'b0;
    frame("post_rst", 3, 7'd3, 7'd0, 128'h7, 7'd3, 1'b0);
    idle_after("post_rst", 7'd3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
